systolic_job_ctrl: RTL

Job sequencer placed in front of `SystolicArray`. It accepts one matrix-multiply job command and gates the upstream x and w vector streams into the array's receive handshakes for exactly the commanded number of vectors. It then waits for the array's `out_rdy` and drains all SIZE×SIZE results in row-major order onto a single val/rdy result stream by driving `out_rsel`/`out_csel`. Vector data bypasses this block; it owns only the handshakes, the counters and the readout addressing.

---
 rtl/systolic_job_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/systolic_job_ctrl.sv
// Job sequencer in front of a SIZE x SIZE systolic array: passes exactly K x/w feed
// handshakes through, then drains every result cell in row-major order as one val/rdy stream.
module systolic_job_ctrl #(
   parameter int SIZE  = 4,
   parameter int NBITS = 16,
   parameter int LBITS = 8
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    cmd_val,
   output logic                    cmd_rdy,
   input  logic [LBITS-1:0]        cmd_len,

   input  logic                    x_in_val,
   output logic                    x_in_rdy,
   input  logic                    w_in_val,
   output logic                    w_in_rdy,

   output logic                    arr_x_val,
   input  logic                    arr_x_rdy,
   output logic                    arr_w_val,
   input  logic                    arr_w_rdy,

   input  logic                    arr_out_rdy,
   output logic [$clog2(SIZE)-1:0] arr_rsel,
   output logic [$clog2(SIZE)-1:0] arr_csel,
   input  logic [NBITS-1:0]        arr_s_out,

   output logic                    res_val,
   input  logic                    res_rdy,
   output logic [NBITS-1:0]        res_data,
   output logic                    res_last,

   output logic                    busy,
   output logic                    done
);

   localparam int             RW      = $clog2(SIZE);
   localparam logic [RW-1:0]  IDX_MAX = RW'(SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [LBITS-1:0] k_q, k_d;
   logic [LBITS-1:0] x_cnt_q, x_cnt_d;
   logic [LBITS-1:0] w_cnt_q, w_cnt_d;
   logic [RW-1:0]    r_q, r_d;
   logic [RW-1:0]    c_q, c_d;
   logic             done_q, done_d;

   logic             x_open, w_open;
   logic             x_fire, w_fire;
   logic             at_last, res_fire;

   // Feed gating is purely combinational so the array sees upstream val/rdy with no added cycle.
   always_comb begin
      x_open    = (state_q == FEED) && (x_cnt_q < k_q);
      w_open    = (state_q == FEED) && (w_cnt_q < k_q);

      arr_x_val = x_open && x_in_val;
      x_in_rdy  = x_open && arr_x_rdy;
      arr_w_val = w_open && w_in_val;
      w_in_rdy  = w_open && arr_w_rdy;

      x_fire    = x_in_val && x_in_rdy;
      w_fire    = w_in_val && w_in_rdy;

      at_last   = (r_q == IDX_MAX) && (c_q == IDX_MAX);

      cmd_rdy   = (state_q == IDLE);
      busy      = (state_q != IDLE);
      res_val   = (state_q == DRAIN);
      res_last  = (state_q == DRAIN) && at_last;
      res_data  = (state_q == DRAIN) ? arr_s_out : '0;
      res_fire  = res_val && res_rdy;

      arr_rsel  = r_q;
      arr_csel  = c_q;
      done      = done_q;
   end

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through the case leaves
      // one unassigned and no latch is inferred.
      state_d = state_q;
      k_d     = k_q;
      x_cnt_d = x_cnt_q;
      w_cnt_d = w_cnt_q;
      r_d     = r_q;
      c_d     = c_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cmd_val) begin
               k_d     = cmd_len;
               x_cnt_d = '0;
               w_cnt_d = '0;
               state_d = (cmd_len != '0) ? FEED : WAIT;
            end
         end

         FEED: begin
            if (x_fire) x_cnt_d = x_cnt_q + 1'b1;
            if (w_fire) w_cnt_d = w_cnt_q + 1'b1;
            // Sides finish independently; leave only once both have delivered K vectors.
            if ((x_cnt_d == k_q) && (w_cnt_d == k_q)) state_d = WAIT;
         end

         WAIT: begin
            if (arr_out_rdy) state_d = DRAIN;
         end

         DRAIN: begin
            if (res_fire) begin
               if (at_last) begin
                  state_d = IDLE;
                  r_d     = '0;
                  c_d     = '0;
                  done_d  = 1'b1;
               end else if (c_q == IDX_MAX) begin
                  c_d = '0;
                  r_d = r_q + 1'b1;
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         x_cnt_q <= '0;
         w_cnt_q <= '0;
         r_q     <= '0;
         c_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_cnt_q <= x_cnt_d;
         w_cnt_q <= w_cnt_d;
         r_q     <= r_d;
         c_q     <= c_d;
         done_q  <= done_d;
      end
   end

endmodule
